traffic_conflict_monitor: RTL and testbench

//  Safety stage directly downstream of the two-road traffic light controller.
//  - Registers the controller's roadA/roadB light codes and forwards them to the lamp drivers.
//  - Checks every cycle for illegal codes, conflicting greens, bad phase sequences and bad dwell times.
//  - On any violation it latches a fault and forces both roads to RED with a flash strobe.
//  - It returns to pass-through only after an operator clear and an all-red recovery interval.

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/light_seq_checker.sv | 66 ++++++
 rtl/traffic_conflict_monitor.sv | 178 +++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light, fault and monitor-state types for the traffic safety stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b10,
        GREEN  = 2'b11
    } light_t;

    // 01 is never produced by a healthy controller.
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;

    // Lower value wins when several violations fire on the same sample.
    typedef enum logic [2:0] {
        FLT_NONE         = 3'd0,
        FLT_ILLEGAL_CODE = 3'd1,
        FLT_CONFLICT     = 3'd2,
        FLT_SKIP_YELLOW  = 3'd3,
        FLT_BAD_SEQ      = 3'd4,
        FLT_SHORT_YELLOW = 3'd5,
        FLT_STUCK_GREEN  = 3'd6
    } fault_t;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FAULT   = 2'd1,
        RECOVER = 2'd2
    } mon_state_t;

    // Per-road violation flags from one light_seq_checker.
    typedef struct packed {
        logic illegal;
        logic skip_yellow;
        logic bad_seq;
        logic short_yellow;
        logic stuck_green;
    } road_flags_t;

endpackage

// File: rtl/light_seq_checker.sv
// Per-road sequence/dwell checker: flags bad codes, transitions and dwell times.
// Latency: flags are combinational on the current sample vs registered history.
// Backpressure: none; a new code is sampled every clock.
module light_seq_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YT    = 15,
    parameter int MAX_GREEN = 60
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  code,
    input  logic        hist_clr,
    output road_flags_t flags
);

    // Dwell saturates one past the green limit; MIN_YT must fit below that.
    localparam int             DW         = $clog2(MAX_GREEN + 2);
    localparam logic [DW-1:0]  DWELL_SAT  = DW'(MAX_GREEN + 1);
    localparam logic [DW-1:0]  DWELL_GMAX = DW'(MAX_GREEN);
    localparam logic [DW-1:0]  DWELL_YMIN = DW'(MIN_YT);

    logic [1:0]    prev;
    logic [DW-1:0] dwell;
    logic          hist_vld;
    logic          same;

    // Current sample repeats the previous one.
    always_comb same = (code == prev);

    // Flags: illegal code always; transition and dwell checks need history.
    always_comb begin
        flags         = '0;
        flags.illegal = (code == CODE_ILLEGAL);
        if (hist_vld) begin
            flags.skip_yellow  = (prev == GREEN)  && (code == RED);
            flags.bad_seq      = (prev == YELLOW) && (code == GREEN);
            flags.short_yellow = (prev == YELLOW) && (code == RED) && (dwell < DWELL_YMIN);
            // dwell counts earlier GREEN samples; this sample makes it dwell+1.
            flags.stuck_green  = (prev == GREEN)  && (code == GREEN) && (dwell >= DWELL_GMAX);
        end
    end

    // History register: previous code, saturating dwell count, valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= RED;
            dwell    <= '0;
            hist_vld <= 1'b0;
        end else if (hist_clr) begin
            prev     <= RED;
            dwell    <= '0;
            hist_vld <= 1'b0;
        end else begin
            prev     <= code;
            hist_vld <= 1'b1;
            if (!hist_vld || !same) begin
                dwell <= DW'(1);
            end else if (dwell != DWELL_SAT) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage: registers road light codes, latches first violation, forces all-red + flash.
// Latency: 1 cycle pass-through in NORMAL; violations force RED on the sampling edge.
// Backpressure: none; inputs are sampled every clock, fault_clr is level-sampled.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YT     = 15,
    parameter int MAX_GREEN  = 60,
    parameter int BLINK_HALF = 5,
    parameter int ALL_RED    = 3
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] roadA_in,
    input  logic [1:0] roadB_in,
    input  logic       fault_clr,
    output logic [1:0] roadA_out,
    output logic [1:0] roadB_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam int            BW         = $clog2(BLINK_HALF + 1);
    localparam int            RW         = $clog2(ALL_RED + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] REC_LAST   = RW'(ALL_RED - 1);

    road_flags_t flags_a;
    road_flags_t flags_b;
    logic        conflict;
    logic        both_red;
    logic        viol;
    fault_t      viol_code;
    logic        hist_clr;

    mon_state_t  state;
    mon_state_t  state_nxt;
    fault_t      code_q;
    fault_t      code_nxt;
    logic [1:0]  a_nxt;
    logic [1:0]  b_nxt;
    logic        flash_nxt;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;

    light_seq_checker #(.MIN_YT(MIN_YT), .MAX_GREEN(MAX_GREEN)) u_chk_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .code     (roadA_in),
        .hist_clr (hist_clr),
        .flags    (flags_a)
    );

    light_seq_checker #(.MIN_YT(MIN_YT), .MAX_GREEN(MAX_GREEN)) u_chk_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .code     (roadB_in),
        .hist_clr (hist_clr),
        .flags    (flags_b)
    );

    // Cross-road checks on the current sample.
    always_comb begin
        conflict = (roadA_in != RED) && (roadB_in != RED);
        both_red = (roadA_in == RED) && (roadB_in == RED);
    end

    // Priority encoder: lowest violation code wins.
    always_comb begin
        viol_code = FLT_NONE;
        if (flags_a.illegal || flags_b.illegal) begin
            viol_code = FLT_ILLEGAL_CODE;
        end else if (conflict) begin
            viol_code = FLT_CONFLICT;
        end else if (flags_a.skip_yellow || flags_b.skip_yellow) begin
            viol_code = FLT_SKIP_YELLOW;
        end else if (flags_a.bad_seq || flags_b.bad_seq) begin
            viol_code = FLT_BAD_SEQ;
        end else if (flags_a.short_yellow || flags_b.short_yellow) begin
            viol_code = FLT_SHORT_YELLOW;
        end else if (flags_a.stuck_green || flags_b.stuck_green) begin
            viol_code = FLT_STUCK_GREEN;
        end
        viol = (viol_code != FLT_NONE);
    end

    // Next state, outputs, blink and recovery counters.
    // A violation on the clearing edge keeps the monitor in FAULT.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        a_nxt     = RED;
        b_nxt     = RED;
        flash_nxt = 1'b0;
        bcnt_nxt  = '0;
        rcnt_nxt  = '0;
        hist_clr  = 1'b0;
        case (state)
            NORMAL: begin
                if (viol) begin
                    state_nxt = FAULT;
                    code_nxt  = viol_code;
                end else begin
                    a_nxt = roadA_in;
                    b_nxt = roadB_in;
                end
            end
            FAULT: begin
                if (!viol && fault_clr && both_red) begin
                    state_nxt = RECOVER;
                end else begin
                    flash_nxt = flash;
                    if (bcnt == BLINK_LAST) begin
                        bcnt_nxt  = '0;
                        flash_nxt = ~flash;
                    end else begin
                        bcnt_nxt = bcnt + BW'(1);
                    end
                end
            end
            RECOVER: begin
                if (viol) begin
                    state_nxt = FAULT;
                    code_nxt  = viol_code;
                end else if (rcnt == REC_LAST) begin
                    state_nxt = NORMAL;
                    code_nxt  = FLT_NONE;
                    hist_clr  = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            default: begin
                state_nxt = NORMAL;
                code_nxt  = FLT_NONE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Output, fault-code and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roadA_out <= RED;
            roadB_out <= RED;
            code_q    <= FLT_NONE;
            flash     <= 1'b0;
            bcnt      <= '0;
            rcnt      <= '0;
        end else begin
            roadA_out <= a_nxt;
            roadB_out <= b_nxt;
            code_q    <= code_nxt;
            flash     <= flash_nxt;
            bcnt      <= bcnt_nxt;
            rcnt      <= rcnt_nxt;
        end
    end

    // fault tracks the registered state, so it changes on the same edge as the outputs.
    always_comb begin
        fault      = (state != NORMAL);
        fault_code = code_q;
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

    localparam int MIN_YT     = 15;
    localparam int MAX_GREEN  = 60;
    localparam int BLINK_HALF = 5;
    localparam int ALL_RED    = 3;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] G = 2'b11;
    localparam logic [1:0] X = 2'b01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] a_in = 2'b00;
    logic [1:0] b_in = 2'b00;
    logic       clr = 1'b0;
    logic [1:0] roadA_out;
    logic [1:0] roadB_out;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    int n_chk = 0;
    int n_fail = 0;

    traffic_conflict_monitor #(
        .MIN_YT(MIN_YT), .MAX_GREEN(MAX_GREEN), .BLINK_HALF(BLINK_HALF), .ALL_RED(ALL_RED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .roadA_in   (a_in),
        .roadB_in   (b_in),
        .fault_clr  (clr),
        .roadA_out  (roadA_out),
        .roadB_out  (roadB_out),
        .fault      (fault),
        .fault_code (fault_code),
        .flash      (flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps every sample since the last (re)seed and derives run lengths by
    // scanning back; modes and flash phase come from elapsed cycle counts.
    int         hist_a[$];
    int         hist_b[$];
    int         m_mode = 0;     // 0 normal, 1 fault, 2 recover
    int         m_code = 0;
    int         m_fcnt = 0;     // cycles since entering fault
    int         m_rcnt = 0;     // recover cycles elapsed
    logic [1:0] e_a = 2'b00;
    logic [1:0] e_b = 2'b00;
    logic       e_flash = 1'b0;

    function automatic int road_viol(input int q[$], input int cur);
        int prev;
        int run;
        if (q.size() == 0) return 0;
        prev = q[q.size()-1];
        run = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] != prev) break;
            run++;
        end
        if (prev == 3 && cur == 0) return 3;
        if (prev == 2 && cur == 3) return 4;
        if (prev == 2 && cur == 0 && run < MIN_YT) return 5;
        if (prev == 3 && cur == 3 && run + 1 > MAX_GREEN) return 6;
        return 0;
    endfunction

    function automatic int lowest(input int x, input int y);
        if (x == 0) return y;
        if (y == 0) return x;
        return (x < y) ? x : y;
    endfunction

    initial begin : model
        int v;
        int old_mode;
        bit reseed;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist_a.delete();
                hist_b.delete();
                m_mode = 0; m_code = 0; m_fcnt = 0; m_rcnt = 0;
                e_a = R; e_b = R; e_flash = 1'b0;
            end else begin
                v = 0;
                if (a_in == X || b_in == X) v = 1;
                else if (a_in != R && b_in != R) v = 2;
                else v = lowest(road_viol(hist_a, int'(a_in)), road_viol(hist_b, int'(b_in)));
                old_mode = m_mode;
                reseed = 1'b0;
                case (m_mode)
                    0: if (v != 0) begin m_mode = 1; m_code = v; m_fcnt = 0; end
                    1: if (v == 0 && clr && a_in == R && b_in == R) begin
                           m_mode = 2; m_rcnt = 0;
                       end else m_fcnt++;
                    default: if (v != 0) begin
                           m_mode = 1; m_code = v; m_fcnt = 0;
                       end else begin
                           m_rcnt++;
                           if (m_rcnt == ALL_RED) begin m_mode = 0; m_code = 0; reseed = 1'b1; end
                       end
                endcase
                e_a = (old_mode == 0 && v == 0) ? a_in : R;
                e_b = (old_mode == 0 && v == 0) ? b_in : R;
                e_flash = (m_mode == 1) ? (((m_fcnt / BLINK_HALF) % 2) == 1) : 1'b0;
                if (reseed) begin
                    hist_a.delete();
                    hist_b.delete();
                end else begin
                    hist_a.push_back(int'(a_in));
                    hist_b.push_back(int'(b_in));
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("cmp_roadA", roadA_out, e_a);
            check("cmp_roadB", roadB_out, e_b);
            check("cmp_fault", fault, (m_mode != 0));
            check("cmp_code", fault_code, m_code);
            check("cmp_flash", flash, e_flash);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic c, input int n);
        a_in = a;
        b_in = b;
        clr  = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_and_recover();
        drive(R, R, 1'b1, 1);
        drive(R, R, 1'b0, 4);
    endtask

    initial begin : stim
        // 1: reset and two legal cycles
        #3;
        check("rst_roadA", roadA_out, R);
        check("rst_roadB", roadB_out, R);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_flash", flash, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            drive(G, R, 1'b0, 45);
            drive(Y, R, 1'b0, 15);
            drive(R, G, 1'b0, 45);
            drive(R, Y, 1'b0, 15);
        end
        check("t1_fault", fault, 0);
        check("t1_code", fault_code, 0);
        check("t1_passB", roadB_out, Y);

        // 2: conflicting greens, then flash timing
        drive(G, Y, 1'b0, 1);
        check("t2_fault", fault, 1);
        check("t2_code", fault_code, 2);
        check("t2_roadA", roadA_out, R);
        check("t2_roadB", roadB_out, R);
        a_in = R;
        b_in = R;
        for (int i = 0; i < 10; i++) begin
            check("t2_flash", flash, (i >= 5) ? 1 : 0);
            @(negedge clk);
        end
        clear_and_recover();
        check("t2_cleared", fault, 0);

        // 3a: green straight to red
        drive(G, R, 1'b0, 5);
        drive(R, R, 1'b0, 1);
        check("t3_skip", fault_code, 3);
        clear_and_recover();
        // 3b: yellow held only 10 cycles
        drive(G, R, 1'b0, 3);
        drive(Y, R, 1'b0, 10);
        drive(R, R, 1'b0, 1);
        check("t3_short", fault_code, 5);
        clear_and_recover();
        // 3c: illegal code with simultaneous skip-yellow on B
        drive(R, G, 1'b0, 3);
        drive(X, R, 1'b0, 1);
        check("t3_illegal", fault_code, 1);
        clear_and_recover();

        // 4: stuck green
        drive(G, R, 1'b0, 60);
        check("t4_60green", fault, 0);
        drive(G, R, 1'b0, 1);
        check("t4_fault", fault, 1);
        check("t4_code", fault_code, 6);

        // 5: clear handling
        drive(G, R, 1'b1, 3);
        check("t5_clr_ignored", fault, 1);
        check("t5_code_kept", fault_code, 6);
        drive(R, R, 1'b0, 1);
        drive(R, R, 1'b1, 1);
        check("t5_rec_fault", fault, 1);
        check("t5_rec_red", roadA_out, R);
        check("t5_rec_flash", flash, 0);
        drive(R, R, 1'b0, 2);
        check("t5_rec_hold", fault, 1);
        drive(G, R, 1'b0, 1);
        check("t5_normal", fault, 0);
        check("t5_code0", fault_code, 0);
        drive(G, R, 1'b0, 1);
        check("t5_pass", roadA_out, G);
        drive(G, R, 1'b1, 2);
        check("t5_clr_normal", fault, 0);
        // violation during recovery re-enters fault with the new code
        drive(R, R, 1'b0, 1);
        check("t5_skip", fault_code, 3);
        drive(R, R, 1'b1, 1);
        drive(R, R, 1'b0, 1);
        drive(G, G, 1'b0, 1);
        check("t5_rec_viol", fault_code, 2);
        check("t5_rec_viol_f", fault, 1);

        // 6: asynchronous reset mid-fault
        drive(R, R, 1'b0, 7);
        check("t6_flash_on", flash, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_roadA", roadA_out, R);
        check("t6_fault", fault, 0);
        check("t6_code", fault_code, 0);
        check("t6_flash", flash, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(R, R, 1'b0, 3);
        drive(G, R, 1'b0, 3);
        check("t6_pass", roadA_out, G);
        check("t6_nofault", fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
